wb_arbiter: RTL and testbench

Write-back arbiter driving the register file's single write port (`rd_write`/`rd_addr`/`rd_data`, 64-bit data, x0 hard-wired zero). It merges single-cycle ALU results with long-latency memory results, buffers memory results in a small FIFO, and keeps a 32-entry pending-register scoreboard. Decode uses the scoreboard to stall on operands whose load has not yet written back.

---
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_arbiter.sv | 111 +++++++++++
 tb/tb_wb_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU and memory result handshakes, scoreboard
// set/query ports and the register-file write port.
interface wb_arbiter_if #(
  parameter int unsigned XLEN = 64
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            pend_set;
  logic [4:0]      pend_rd;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_write;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           pend_set, pend_rd, rs1_addr, rs2_addr,
    output alu_ready, mem_ready, rs1_busy, rs2_busy, rd_write, rd_addr, rd_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           pend_set, pend_rd, rs1_addr, rs2_addr,
    input  alu_ready, mem_ready, rs1_busy, rs2_busy, rd_write, rd_addr, rd_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and FIFO-buffered load results onto
// the single register-file write port, and tracks loads pending write-back.
module wb_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  localparam int unsigned RD_W  = 5;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NREG  = 32;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  wb_entry_t        fifo_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [STV_W-1:0] starve_q;
  logic [NREG-1:0]  pending_q;

  logic             fifo_empty_c;
  logic             force_c;
  logic             alu_wr_c;
  logic             pop_c;
  logic             push_c;
  logic             sel_valid_c;
  wb_entry_t        head_c;
  wb_entry_t        sel_c;
  logic [STV_W-1:0] starve_d;
  logic [NREG-1:0]  pending_d;

  // Selection, handshakes, starvation and scoreboard next-state
  always_comb begin
    fifo_empty_c  = (count_q == '0);
    head_c        = fifo_q[rd_ptr_q];
    force_c       = !reset && !fifo_empty_c && (starve_q == STV_W'(STARVE_LIMIT));
    bus.alu_ready = !force_c;
    bus.mem_ready = !reset && (count_q != CNT_W'(DEPTH));
    alu_wr_c      = bus.alu_valid && !force_c && (bus.alu_rd != '0);
    // A forced cycle never has an ALU write, so the head pops then as well
    pop_c         = !fifo_empty_c && !alu_wr_c;
    push_c        = bus.mem_valid && bus.mem_ready && (bus.mem_rd != '0);
    sel_valid_c   = alu_wr_c || pop_c;
    sel_c         = pop_c ? head_c : {bus.alu_rd, bus.alu_data};

    starve_d = starve_q;
    if (fifo_empty_c || pop_c) begin
      starve_d = '0;
    end else if (starve_q != STV_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STV_W'(1);
    end

    // Set is applied after clear so a same-cycle set wins
    pending_d = pending_q;
    if (pop_c) begin
      pending_d[head_c.rd] = 1'b0;
    end
    if (bus.pend_set && (bus.pend_rd != '0)) begin
      pending_d[bus.pend_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;

    bus.rs1_busy = (bus.rs1_addr != '0) && pending_q[bus.rs1_addr];
    bus.rs2_busy = (bus.rs2_addr != '0) && pending_q[bus.rs2_addr];
  end

  // FIFO storage carries no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= {bus.mem_rd, bus.mem_data};
    end
  end

  // Control state and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      pending_q    <= '0;
      bus.rd_write <= 1'b0;
      bus.rd_addr  <= '0;
      bus.rd_data  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q      <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      starve_q     <= starve_d;
      pending_q    <= pending_d;
      bus.rd_write <= sel_valid_c;
      if (sel_valid_c) begin
        bus.rd_addr <= sel_c.rd;
        bus.rd_data <= sel_c.data;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts
// handshakes, busy flags and the ordered stream of register-file writes.
module tb_wb_arbiter;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  wb_arbiter_if #(.XLEN(XLEN)) bus ();

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  ent_t        exp_q[$];
  ent_t        m_fifo[$];
  int          m_starve = 0;
  logic [31:0] m_pend   = '0;
  bit          m_prev_wr = 1'b0;
  bit          m_chk_wr  = 1'b0;
  bit          m_acc     = 1'b0;
  ent_t        mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
  endtask

  // Reference model: one call per cycle, after inputs settle
  task automatic model_step();
    bit   force_sel, alu_wr, pop, sel, mready;
    ent_t s;
    if (m_chk_wr) check("rd_write", 64'(bus.rd_write), 64'(m_prev_wr));
    m_chk_wr = 1'b1;
    m_acc    = 1'b0;
    if (reset) begin
      check("alu_ready_in_reset", 64'(bus.alu_ready), 64'(1));
      check("mem_ready_in_reset", 64'(bus.mem_ready), 64'(0));
      m_fifo.delete();
      m_starve  = 0;
      m_pend    = '0;
      m_prev_wr = 1'b0;
      return;
    end
    mready    = (m_fifo.size() < DEPTH);
    force_sel = (m_starve == LIMIT) && (m_fifo.size() > 0);
    check("alu_ready", 64'(bus.alu_ready), 64'(!force_sel));
    check("mem_ready", 64'(bus.mem_ready), 64'(mready));
    check("rs1_busy", 64'(bus.rs1_busy), 64'((bus.rs1_addr != 0) && m_pend[bus.rs1_addr]));
    check("rs2_busy", 64'(bus.rs2_busy), 64'((bus.rs2_addr != 0) && m_pend[bus.rs2_addr]));

    alu_wr = bus.alu_valid && !force_sel && (bus.alu_rd != 0);
    pop    = force_sel || (!alu_wr && m_fifo.size() > 0);
    sel    = alu_wr || pop;
    if (pop) begin
      s = m_fifo.pop_front();
      m_pend[s.rd] = 1'b0;
      m_starve = 0;
    end else begin
      s = {bus.alu_rd, bus.alu_data};
      if (m_fifo.size() == 0) m_starve = 0;
      else if (m_starve < LIMIT) m_starve = m_starve + 1;
    end
    if (bus.pend_set && bus.pend_rd != 0) m_pend[bus.pend_rd] = 1'b1;
    if (bus.mem_valid && mready) begin
      m_acc = 1'b1;
      if (bus.mem_rd != 0) m_fifo.push_back({bus.mem_rd, bus.mem_data});
    end
    if (sel) exp_q.push_back(s);
    m_prev_wr = sel;
  endtask

  task automatic cyc(input bit rst, input bit av, input logic [4:0] ard, input logic [63:0] ad,
                     input bit mv, input logic [4:0] mrd, input logic [63:0] md,
                     input bit ps, input logic [4:0] prd, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = md;
    bus.pend_set  = ps;
    bus.pend_rd   = prd;
    bus.rs1_addr  = r1;
    bus.rs2_addr  = r2;
    #1;
    model_step();
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, r1, r2);
  endtask

  // Monitor: every presented write must match the oldest expected write
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rd_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write actual rd=%0d data=%0h expected=no write",
                   bus.rd_addr, bus.rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_addr", 64'(bus.rd_addr), 64'(mon_e.rd));
          check("rd_data", 64'(bus.rd_data), mon_e.data);
        end
      end
    end
  end

  initial begin
    int idx;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.pend_set  = 1'b0; bus.pend_rd = '0;
    bus.rs1_addr  = '0;   bus.rs2_addr = '0;

    cyc(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    // ALU write, then an rd 0 ALU transfer that must not write
    cyc(1'b0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    cyc(1'b0, 1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Pending load on x7 tracked until its write-back
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hDEAD, 1'b0, 5'd0, 5'd7, 5'd0);
    for (int i = 0; i < 4; i++) idle(5'd7, 5'd0);

    // Sustained ALU traffic against three queued loads: starvation forcing
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(1'b0, 1'b1, 5'(c % 31 + 1), 64'(c + 100), idx < 3, 5'(10 + idx), 64'hA0 + 64'(idx),
          1'b0, 5'd0, 5'd10, 5'd11);
      if (m_acc) idx++;
    end
    for (int i = 0; i < 4; i++) idle(5'd0, 5'd0);

    // Same-cycle set and pop of x9: set wins
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 5'd9, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    idle(5'd9, 5'd0);

    // Reset with two queued loads and three pending bits
    cyc(1'b0, 1'b1, 5'd1, 64'h11, 1'b1, 5'd12, 64'hC12, 1'b1, 5'd12, 5'd12, 5'd13);
    cyc(1'b0, 1'b1, 5'd2, 64'h22, 1'b1, 5'd13, 64'hC13, 1'b1, 5'd13, 5'd12, 5'd13);
    cyc(1'b0, 1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0, 1'b1, 5'd14, 5'd14, 5'd13);
    cyc(1'b1, 1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd12, 5'd13);
    idle(5'd12, 5'd13);
    idle(5'd14, 5'd9);
    idle(5'd12, 5'd14);

    // Randomized traffic, including occasional resets and x0 destinations
    for (int c = 0; c < 800; c++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)),
          {$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          {$urandom, $urandom}, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 20; i++) idle(5'd0, 5'd0);

    check("writes_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
